// File: rtl/alu_share_arbiter_pkg.sv
// Shared ALU control encodings and helpers for the two-port ALU share arbiter.
package alu_share_arbiter_pkg;

  localparam int W_DEFAULT = 32;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;

  function automatic logic ctrl_legal(input logic [2:0] ctrl);
    return (ctrl == ALU_AND) || (ctrl == ALU_OR) || (ctrl == ALU_ADD) || (ctrl == ALU_SUB);
  endfunction

endpackage

// File: rtl/alu_rr_picker.sv
// Two-way round-robin picker: on a tie the port that did not win last time is granted.
module alu_rr_picker (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic grant,
  output logic any
);

  always_comb begin
    any = valid0 | valid1;
    if (valid0 && valid1) grant = ~last_grant;
    else                  grant = valid1;
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU between the EX stage (port 0) and the
// branch/address unit (port 1): operand register -> response register pipeline.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [2:0]   req0_ctrl,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic [2:0]   req1_ctrl,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_ctrl,
  input  logic [W-1:0] alu_result,
  input  logic         alu_zero,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic         resp_id,
  output logic [W-1:0] resp_result,
  output logic         resp_zero,
  output logic         resp_err
);

  logic         op_valid;
  logic         op_id;
  logic         op_err;
  logic         last_grant;
  logic         grant;
  logic         pick_any;
  logic         stall;
  logic         advance;
  logic         accept;
  logic [W-1:0] sel_a;
  logic [W-1:0] sel_b;
  logic [2:0]   sel_ctrl;

  alu_rr_picker u_picker (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .any        (pick_any)
  );

  assign stall   = resp_valid & ~resp_ready;
  assign advance = ~op_valid | ~stall;

  // Readies are masked while reset is held so no requester sees a phantom accept.
  assign req0_ready = rst_n & advance & pick_any & ~grant & req0_valid;
  assign req1_ready = rst_n & advance & pick_any &  grant & req1_valid;
  assign accept     = req0_ready | req1_ready;

  always_comb begin
    sel_a    = grant ? req1_a    : req0_a;
    sel_b    = grant ? req1_b    : req0_b;
    sel_ctrl = grant ? req1_ctrl : req0_ctrl;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_valid   <= 1'b0;
      op_id      <= 1'b0;
      op_err     <= 1'b0;
      last_grant <= 1'b1;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_ctrl   <= '0;
    end else if (advance) begin
      if (accept) begin
        op_valid   <= 1'b1;
        op_id      <= grant;
        last_grant <= grant;
        alu_a      <= sel_a;
        alu_b      <= sel_b;
        // Illegal codes run a harmless ADD; the result is masked at capture.
        alu_ctrl   <= ctrl_legal(sel_ctrl) ? sel_ctrl : ALU_ADD;
        op_err     <= ~ctrl_legal(sel_ctrl);
      end else begin
        op_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid  <= 1'b0;
      resp_id     <= 1'b0;
      resp_result <= '0;
      resp_zero   <= 1'b0;
      resp_err    <= 1'b0;
    end else if (op_valid && !stall) begin
      resp_valid  <= 1'b1;
      resp_id     <= op_id;
      resp_result <= op_err ? '0 : alu_result;
      resp_zero   <= op_err ? 1'b1 : alu_zero;
      resp_err    <= op_err;
    end else if (resp_valid && resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU on the alu_* side.
module tb_alu_share_arbiter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]   req0_ctrl, req1_ctrl;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic [2:0]   alu_ctrl;
  logic         alu_zero;
  logic         resp_valid, resp_ready, resp_id, resp_zero, resp_err;
  logic [W-1:0] resp_result;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result), .alu_zero(alu_zero),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_zero(resp_zero), .resp_err(resp_err)
  );

  // External ALU model; unknown codes compute a+b|1 so masking is visible.
  always_comb begin
    case (alu_ctrl)
      3'b010:  alu_result = alu_a + alu_b;
      3'b110:  alu_result = alu_a - alu_b;
      3'b000:  alu_result = alu_a & alu_b;
      3'b001:  alu_result = alu_a | alu_b;
      default: alu_result = (alu_a + alu_b) | 32'd1;
    endcase
    alu_zero = (alu_result == '0);
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_resp(input string tag, input logic v, input logic id,
                          input logic [W-1:0] res, input logic z, input logic e);
    chk({tag, ".valid"},  W'(resp_valid), W'(v));
    chk({tag, ".id"},     W'(resp_id),    W'(id));
    chk({tag, ".result"}, resp_result,    res);
    chk({tag, ".zero"},   W'(resp_zero),  W'(z));
    chk({tag, ".err"},    W'(resp_err),   W'(e));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; resp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_ctrl = 3'b010;
    req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd4; req1_ctrl = 3'b010;
    #1;
    tick(); tick();
    chk_resp("reset", 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    chk("reset.ready0", W'(req0_ready), W'(1'b0));
    chk("reset.ready1", W'(req1_ready), W'(1'b0));
    chk("reset.alu_a", alu_a, 32'd0);
    chk("reset.alu_ctrl", W'(alu_ctrl), W'(3'b000));

    // Single ADD from requester 0.
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd7; req0_ctrl = 3'b010;
    #1 chk("single.ready0", W'(req0_ready), W'(1'b1));
    tick();
    req0_valid = 1'b0;
    chk("single.alu_a", alu_a, 32'd5);
    chk("single.resp_valid_early", W'(resp_valid), W'(1'b0));
    tick();
    chk_resp("single", 1'b1, 1'b0, 32'd12, 1'b0, 1'b0);
    tick();
    chk("single.drained", W'(resp_valid), W'(1'b0));

    // Requester 1 alone, four back-to-back ADDs.
    for (int i = 0; i < 4; i++) begin
      req1_valid = 1'b1; req1_a = W'(i); req1_b = 32'd100; req1_ctrl = 3'b010;
      #1 chk("b2b.ready1", W'(req1_ready), W'(1'b1));
      tick();
      if (i > 0) chk_resp("b2b", 1'b1, 1'b1, W'(99 + i), 1'b0, 1'b0);
    end
    req1_valid = 1'b0;
    tick();
    chk_resp("b2b.last", 1'b1, 1'b1, 32'd103, 1'b0, 1'b0);
    tick();
    chk("b2b.drained", W'(resp_valid), W'(1'b0));

    // Tie: grants alternate 0,1,0,1 (last winner was requester 1).
    req0_valid = 1'b1; req0_a = 32'd9; req0_b = 32'd9; req0_ctrl = 3'b110;
    req1_valid = 1'b1; req1_a = 32'd4; req1_b = 32'd1; req1_ctrl = 3'b001;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("tie.ready0", W'(req0_ready), W'(i % 2 == 0));
      chk("tie.ready1", W'(req1_ready), W'(i % 2 == 1));
      tick();
      if (i > 0) chk_resp("tie", 1'b1, 1'((i - 1) % 2), ((i - 1) % 2 == 1) ? 32'd5 : 32'd0,
                          ((i - 1) % 2 == 0), 1'b0);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    chk_resp("tie.last", 1'b1, 1'b1, 32'd5, 1'b0, 1'b0);
    tick();

    // Backpressure with two queued ops plus a third held off by the stall.
    resp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd1;  req0_b = 32'd2;  req0_ctrl = 3'b010;
    req1_valid = 1'b1; req1_a = 32'd10; req1_b = 32'd20; req1_ctrl = 3'b010;
    #1 chk("bp.ready0", W'(req0_ready), W'(1'b1));
    tick();
    req0_valid = 1'b0;
    #1 chk("bp.ready1", W'(req1_ready), W'(1'b1));
    tick();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd100; req0_b = 32'd1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp.stall_ready0", W'(req0_ready), W'(1'b0));
      chk_resp("bp.hold", 1'b1, 1'b0, 32'd3, 1'b0, 1'b0);
      chk("bp.alu_a_hold", alu_a, 32'd10);
      tick();
    end
    resp_ready = 1'b1;
    #1 chk("bp.release_ready0", W'(req0_ready), W'(1'b1));
    tick();
    req0_valid = 1'b0;
    chk_resp("bp.second", 1'b1, 1'b1, 32'd30, 1'b0, 1'b0);
    tick();
    chk_resp("bp.third", 1'b1, 1'b0, 32'd101, 1'b0, 1'b0);
    tick();
    chk("bp.drained", W'(resp_valid), W'(1'b0));

    // Illegal ctrl from requester 1, then a legal AND clears the error flag.
    req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd4; req1_ctrl = 3'b111;
    tick();
    req1_valid = 1'b0;
    chk("illegal.alu_ctrl", W'(alu_ctrl), W'(3'b010));
    tick();
    chk_resp("illegal", 1'b1, 1'b1, 32'd0, 1'b1, 1'b1);
    req0_valid = 1'b1; req0_a = 32'd12; req0_b = 32'd10; req0_ctrl = 3'b000;
    tick();
    req0_valid = 1'b0;
    tick();
    chk_resp("and", 1'b1, 1'b0, 32'd8, 1'b0, 1'b0);

    // Reset mid-operation, then the first tie goes to requester 0.
    req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd1; req1_ctrl = 3'b010;
    tick();
    req0_valid = 1'b1; req0_a = 32'd2; req0_b = 32'd2; req0_ctrl = 3'b010;
    #2 rst_n = 1'b0;
    #1;
    chk_resp("midrst", 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    chk("midrst.ready0", W'(req0_ready), W'(1'b0));
    chk("midrst.ready1", W'(req1_ready), W'(1'b0));
    chk("midrst.alu_a", alu_a, 32'd0);
    tick();
    chk("midrst.no_pulse", W'(resp_valid), W'(1'b0));
    rst_n = 1'b1;
    #1;
    chk("postrst.ready0", W'(req0_ready), W'(1'b1));
    chk("postrst.ready1", W'(req1_ready), W'(1'b0));
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("postrst.resp_valid", W'(resp_valid), W'(1'b0));
    tick();
    chk_resp("postrst", 1'b1, 1'b0, 32'd4, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
